// File: rtl/decode_ctrl_pkg.sv
// decode_ctrl_pkg: shared types for the decode control buffer.
// Holds imm_fmt encodings, RV32 major opcodes and buffer state encoding.
package decode_ctrl_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_FENCE   = 7'b0001111;
    localparam logic [6:0] OP_CUSTOM2 = 7'b1011011;

endpackage

// File: rtl/decode_ctrl_fmt_classify.sv
// fmt_classify: combinational RV32 opcode -> immediate format classifier.
// Ports: instr (in, 32), imm_fmt (out, 3), illegal (out, 1).
// Macro CHERI_OPCODE_EN: accept custom-2 (1011011) as an I-format opcode.
module fmt_classify
    import decode_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [2:0]  imm_fmt,
    output logic        illegal
);

    // Only the major opcode matters; the low two bits are part of it,
    // so a compressed encoding never matches and lands in default.
    logic w_unused;
    assign w_unused = ^instr[31:7];

    always_comb begin
        imm_fmt = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: imm_fmt = FMT_I;
            OP_STORE:                            imm_fmt = FMT_S;
            OP_BRANCH:                           imm_fmt = FMT_B;
            OP_LUI, OP_AUIPC:                    imm_fmt = FMT_U;
            OP_JAL:                              imm_fmt = FMT_J;
            OP_OP, OP_FENCE:                     imm_fmt = FMT_NONE;
`ifdef CHERI_OPCODE_EN
            OP_CUSTOM2:                          imm_fmt = FMT_I;
`endif
            default:                             illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: 2-entry in-order instruction buffer with push-time
// immediate-format classification.
// Ports: clk, rst (sync, active-high), flush;
//   in_valid/in_ready/in_instr/in_pc   - fetch side push;
//   out_valid/out_ready/out_instr/out_pc/imm_fmt/illegal - head entry;
//   occupancy - entries held (0..2).
// Macro CHERI_OPCODE_EN (via fmt_classify): custom-2 classifies as I.
module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [2:0]      imm_fmt,
    output logic            illegal,
    output logic [1:0]      occupancy
);

    state_e r_state;
    state_e w_next;

    logic w_push;
    logic w_pop;
    logic [2:0] w_fmt;
    logic w_ill;

    // Slot 0 is always the head; slot 1 only holds the second entry in FULL.
    logic [31:0]     r_instr0;
    logic [PC_W-1:0] r_pc0;
    logic [2:0]      r_fmt0;
    logic            r_ill0;
    logic [31:0]     r_instr1;
    logic [PC_W-1:0] r_pc1;
    logic [2:0]      r_fmt1;
    logic            r_ill1;

    fmt_classify u_cls (
        .instr   (in_instr),
        .imm_fmt (w_fmt),
        .illegal (w_ill)
    );

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) w_next = ST_ONE;
                end
                ST_ONE: begin
                    if (w_push && !w_pop) w_next = ST_FULL;
                    else if (w_pop && !w_push) w_next = ST_EMPTY;
                end
                ST_FULL: begin
                    if (w_pop) w_next = ST_ONE;
                end
                default: w_next = ST_EMPTY;
            endcase
        end
    end

    // Flushed entries keep their stale payload; out_valid hides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr0 <= '0;
            r_pc0    <= '0;
            r_fmt0   <= FMT_NONE;
            r_ill0   <= 1'b0;
            r_instr1 <= '0;
            r_pc1    <= '0;
            r_fmt1   <= FMT_NONE;
            r_ill1   <= 1'b0;
        end else if (!flush) begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_instr0 <= in_instr;
                        r_pc0    <= in_pc;
                        r_fmt0   <= w_fmt;
                        r_ill0   <= w_ill;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        r_instr0 <= in_instr;
                        r_pc0    <= in_pc;
                        r_fmt0   <= w_fmt;
                        r_ill0   <= w_ill;
                    end else if (w_push) begin
                        r_instr1 <= in_instr;
                        r_pc1    <= in_pc;
                        r_fmt1   <= w_fmt;
                        r_ill1   <= w_ill;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_instr0 <= r_instr1;
                        r_pc0    <= r_pc1;
                        r_fmt0   <= r_fmt1;
                        r_ill0   <= r_ill1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_instr = r_instr0;
    assign out_pc    = r_pc0;
    assign imm_fmt   = r_fmt0;
    assign illegal   = r_ill0;
    assign occupancy = r_state;

endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: scoreboard bench for decode_ctrl.
// Directed scenarios followed by randomized push/pop/flush/reset traffic.
module tb_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  imm_fmt;
    logic        illegal;
    logic [1:0]  occupancy;

    decode_ctrl #(.PC_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .imm_fmt   (imm_fmt),
        .illegal   (illegal),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

`ifdef CHERI_OPCODE_EN
    localparam bit CHERI = 1'b1;
`else
    localparam bit CHERI = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        int          fmt;
        bit          ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    bit   en = 1'b0;
    bit   m_rdy = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference classification from the opcode table.
    function automatic void ref_cls(input logic [31:0] w,
                                    output int f, output bit ill);
        logic [6:0] op;
        op  = w[6:0];
        f   = 0;
        ill = 1'b0;
        if (op inside {7'h03, 7'h13, 7'h67, 7'h73}) f = 1;
        else if (op == 7'h23) f = 2;
        else if (op == 7'h63) f = 3;
        else if (op inside {7'h37, 7'h17}) f = 4;
        else if (op == 7'h6F) f = 5;
        else if (op inside {7'h33, 7'h0F}) f = 0;
        else if (CHERI && op == 7'h5B) f = 1;
        else ill = 1'b1;
    endfunction

    // Monitor: compares DUT head/state against the model queue.
    always @(negedge clk) begin
        if (en) begin
            m_rdy = (q.size() < 2);
            chk("occupancy", {30'b0, occupancy}, q.size());
            chk("in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
            chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            if (out_valid && q.size() > 0) begin
                chk("out_instr", out_instr, q[0].instr);
                chk("out_pc", out_pc, q[0].pc);
                chk("imm_fmt", {29'b0, imm_fmt}, q[0].fmt);
                chk("illegal", {31'b0, illegal}, {31'b0, q[0].ill});
            end
            if (rst || flush) q.delete();
            else if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        end
    end

    task automatic step(input bit iv, input logic [31:0] ins,
                        input logic [31:0] pc, input bit ordy,
                        input bit fl, input bit rs);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        @(negedge clk);
        #1;
        if (en && iv && m_rdy && !fl && !rs) begin
            e.instr = ins;
            e.pc    = pc;
            ref_cls(ins, e.fmt, e.ill);
            q.push_back(e);
        end
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0] ops [13];
        logic [31:0] w;
        ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
                7'h17, 7'h6F, 7'h33, 7'h0F, 7'h5B, 7'h7F};
        w = $urandom;
        if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 12)];
        return w;
    endfunction

    initial begin
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        en = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_fmt", {29'b0, imm_fmt}, 32'd0);
        chk("rst_ill", {31'b0, illegal}, 32'd0);

        // addi appears one cycle later as I-format
        step(1, 32'h00500093, 32'h100, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_fmt", {29'b0, imm_fmt}, 32'd1);
        step(0, 0, 0, 1, 0, 0);

        // fill to FULL with sw, beq, then drain
        step(1, 32'h00112023, 32'h104, 0, 0, 0);
        step(1, 32'hFE000EE3, 32'h108, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("full_ready", {31'b0, in_ready}, 32'd0);
        chk("full_occ", {30'b0, occupancy}, 32'd2);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // simultaneous push/pop in ONE
        step(1, 32'h00000013, 32'h200, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h00100093, 32'h204 + 32'(4 * i), 1, 0, 0);
        end
        step(0, 0, 0, 1, 0, 0);

        // flush in FULL drops the offered instruction
        step(1, 32'h00000013, 32'h300, 0, 0, 0);
        step(1, 32'h00000037, 32'h304, 0, 0, 0);
        step(1, 32'h0000006F, 32'h308, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("flush_occ", {30'b0, occupancy}, 32'd0);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);

        // custom-2 opcode
        step(1, 32'h0000005B, 32'h400, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("c2_ill", {31'b0, illegal}, CHERI ? 32'd0 : 32'd1);
        chk("c2_fmt", {29'b0, imm_fmt}, CHERI ? 32'd1 : 32'd0);
        step(0, 0, 0, 1, 0, 0);

        // reset mid-transfer
        step(1, 32'h00000013, 32'h500, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("rst2_valid", {31'b0, out_valid}, 32'd0);
        chk("rst2_ready", {31'b0, in_ready}, 32'd1);
        chk("rst2_instr", out_instr, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rnd_instr(), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 199) == 0);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
        chk("drained_occ", {30'b0, occupancy}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 Parameter PC_W, default 32: width of in_pc and out_pc.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 flush  input  1  discards all buffered entries.
REQ-005 in_valid  input  1  fetch side offers an instruction.
REQ-006 in_ready  output  1  block accepts the offered instruction.
REQ-007 in_instr  input  32  raw RV32 instruction word.
REQ-008 in_pc  input  PC_W  PC of in_instr.
REQ-009 out_valid  output  1  head entry available to the decode/immediate datapath.
REQ-010 out_ready  input  1  consumer takes the head entry.
REQ-011 out_instr  output  32  head instruction word.
REQ-012 out_pc  output  PC_W  head PC.
REQ-013 imm_fmt  output  3  immediate-format select for the head entry: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-014 illegal  output  1  head entry has an unrecognised opcode.
REQ-015 occupancy  output  2  entries held (0..2).

Function
REQ-016 The block SHALL be a 2-entry in-order buffer with states EMPTY, ONE and FULL.
REQ-017 Push SHALL occur when in_valid and in_ready are both high; pop SHALL occur when out_valid and out_ready are both high.
REQ-018 Ready and valid SHALL be registered-state decodes: in_ready = (state != FULL) and out_valid = (state != EMPTY); neither SHALL depend combinationally on in_valid or out_ready.
REQ-019 Transitions SHALL be:
- EMPTY, push -> ONE
- ONE, push only -> FULL
- ONE, pop only -> EMPTY
- ONE, push and pop -> ONE
- FULL, pop -> ONE
- all other cases hold state.
REQ-020 A pushed entry SHALL appear on the outputs no earlier than the cycle after the push (latency 1); there SHALL be no combinational bypass.
REQ-021 At push, the block SHALL classify the instruction and store imm_fmt and illegal with the entry.
- opcode 0000011, 0010011, 1100111, 1110011 -> I
- 0100011 -> S
- 1100011 -> B
- 0110111, 0010111 -> U
- 1101111 -> J
- 0110011, 0001111 -> NONE, not illegal
- any other opcode, or instr[1:0] != 2'b11 -> NONE, illegal = 1
REQ-022 Entries SHALL leave in push order; head outputs SHALL remain stable while out_valid is high and out_ready is low.
REQ-023 flush SHALL force state EMPTY at the next edge and SHALL take priority over a push or pop in the same cycle; an instruction offered during flush SHALL be dropped.
REQ-024 occupancy SHALL equal 0, 1 and 2 for EMPTY, ONE and FULL respectively.

Reset
REQ-025 On rst high at a clock edge, the state SHALL become EMPTY: out_valid 0, in_ready 1, occupancy 0, imm_fmt 0, illegal 0.
REQ-026 On the same reset, out_instr and out_pc SHALL be 0.
REQ-027 rst SHALL override flush, push and pop.
REQ-028 Reset asserted mid-transfer SHALL discard all entries without producing a pop.

Configuration
REQ-029 Macro CHERI_OPCODE_EN: when defined, opcode 1011011 (CHERI custom-2) SHALL classify as I with illegal = 0.
REQ-030 When CHERI_OPCODE_EN is undefined, opcode 1011011 SHALL classify as NONE with illegal = 1.

Structure
REQ-031 A shared package SHALL hold the imm_fmt encodings, the RV32 opcode constants and the state encoding.
REQ-032 Classification SHALL be a combinational sub-module fmt_classify (instr in; imm_fmt and illegal out), instantiated once on the push path.

Verification
REQ-033 Reset, then push in_instr 0x00500093 (addi) with in_pc 0x100 -> next cycle out_valid 1, imm_fmt 1, illegal 0, out_pc 0x100, occupancy 1.
REQ-034 Hold out_ready 0 and push 0x00112023 (sw), then 0xFE000EE3 (beq) -> in_ready 0 after the 2nd push, occupancy 2; raise out_ready -> sw pops with imm_fmt 2, then beq with imm_fmt 3.
REQ-035 In state ONE, push and pop in the same cycle for 4 cycles -> occupancy stays 1 and the PCs emerge in order.
REQ-036 In FULL, assert flush with in_valid 1 -> next cycle occupancy 0, out_valid 0, and the offered instruction is never output.
REQ-037 Push 0x0000005B -> illegal 1, imm_fmt 0 without CHERI_OPCODE_EN; illegal 0, imm_fmt 1 with it.
REQ-038 Push 0x00000013, then assert rst while out_ready is low -> next cycle out_valid 0, in_ready 1, out_instr 0.
